core_ecc_scheduler: RTL and testbench
=====================================

# core_ecc_scheduler

Clocked scheduler that shares one Hamming(7,4) ECC engine between the node's data-generator ingress and its router ingress. Each cycle it arbitrates contested requests with alternating priority. Generator words are encoded into 11-bit flits for the network; router flits are checked and corrected into 8-bit bucket words. It sits between the node's generator/router ports and its network-output and data-bucket sinks.

## Interface
- `CTRL_NET`, 2'd2: control code driven on `net_ctrl` with every encoded flit.
- `CNT_W`, 16: width of the statistics counters.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: reset is synchronous and active-high.
- `dg_valid` in 1, `dg_ready` out 1, `dg_data` in 8: generator word {data[7:4], addr[3:0]}.
- `rt_valid` in 1, `rt_ready` out 1, `rt_data` in 11: router flit {codeword[10:4], addr[3:0]}.
- `net_valid` out 1, `net_ready` in 1, `net_data` out 11, `net_ctrl` out 2: encoded flit to the network.
- `db_valid` out 1, `db_ready` in 1, `db_data` out 8: corrected word to the bucket.
- `err_corrected` out 1: one-cycle pulse when a decoded flit had a nonzero syndrome.
- `busy` out 1: high in any state other than IDLE.
- `enc_count`, `dec_count`, `corr_count` out CNT_W: saturating event counters.

## Operation
- The FSM has three states: IDLE, ENC_HOLD and DEC_HOLD. The priority pointer `pri` selects the generator when 0 and the router when 1.
- In IDLE, the grant is combinational:
  - Only one side valid: grant that side.
  - Both valid: grant the `pri` side, then toggle `pri`.
  - Uncontested grants leave `pri` unchanged.
- `dg_ready` = IDLE && grant_dg. `rt_ready` = IDLE && grant_rt. At most one ready is high per cycle, and both readies are 0 outside IDLE.
- Encode path: on a dg handshake, register the 11-bit encoded flit, set `net_ctrl`=CTRL_NET, and go to ENC_HOLD. Bit mapping:
  - out[3:0]=d[3:0]; out[6]=d4; out[8]=d5; out[9]=d6; out[10]=d7.
  - out[4]=o6^o8^o10; out[5]=o6^o9^o10; out[7]=o8^o9^o10.
- Decode path: on an rt handshake, correct and register the bucket word, then go to DEC_HOLD.
  - Let r=rt_data[10:4].
  - Syndrome bits: s0=r0^r2^r4^r6; s1=r1^r2^r5^r6; s2=r3^r4^r5^r6.
  - If s≠0, flip r[s-1].
  - db_data={r6,r5,r4,r2,rt_data[3:0]}.
- ENC_HOLD: `net_valid`=1. `net_data` and `net_ctrl` stay stable until `net_ready`; on that handshake, go to IDLE.
- DEC_HOLD: `db_valid`=1. `db_data` stays stable until `db_ready`; on that handshake, go to IDLE.
- Counters: `enc_count` increments on each dg handshake, `dec_count` on each rt handshake, `corr_count` on each nonzero syndrome. All three saturate at all-ones and never wrap.
- Double-bit errors are miscorrected silently. This is the defined behaviour; no detection is performed.

## Timing
- Reset values:
  - FSM=IDLE, `pri`=0.
  - `net_valid`=`db_valid`=0; `net_data`=0, `net_ctrl`=0, `db_data`=0.
  - `err_corrected`=0, `busy`=0; all counters 0.
- Latency: an input handshake in cycle N makes the output valid from cycle N+1.
- Throughput: if the sink is ready immediately, one word completes every 2 cycles. The next grant happens in the cycle after the output handshake.
- `err_corrected` pulses in cycle N+1, aligned with the rising edge of `db_valid`.
- Inputs that are valid while the block is not in IDLE stay pending and are not dropped. Valid must not be withdrawn before the corresponding ready.
- Simultaneous requests arriving in the cycle of an output handshake are arbitrated in the following IDLE cycle.
- Synchronous reset mid-hold drops the held word, clears the counters, and deasserts all valids in the next cycle.

## Structure
- Package `core_ecc_pkg` holds:
  - the state enum;
  - the CTRL_NET default;
  - functions `ham_encode(8b)->11b` and `ham_correct(11b)->{8b word, 3b syndrome}`.
- One sub-module, `ecc_unit`: purely combinational encode and correct, instantiated once and shared by both paths. The FSM, arbiter, output registers and counters live in the top level.

## Test plan
- Encode: dg_data=0xA5, net_ready=1 → net_data=0x525, net_ctrl=2 in cycle N+1; enc_count=1.
- Clean decode: rt_data=0x525 → db_data=0xA5; no err_corrected pulse; dec_count=1.
- Single-bit error: rt_data=0x425 (bit 8 flipped) → syndrome 5, db_data=0xA5, one-cycle err_corrected pulse, corr_count=1. Repeat for every one of bits 4–10.
- Contention: dg_valid and rt_valid both held from reset → grant order dg, rt, dg, rt…; `pri` toggles on each contested grant. A lone rt request leaves `pri` unchanged.
- Backpressure: net_ready=0 for 5 cycles → net_data is stable, and both readies stay 0 until the handshake.
- Reset and saturation: assert reset during DEC_HOLD → all outputs return to their reset values in the next cycle. With CNT_W=4, 20 encodes → enc_count=15.

Source files
------------

// File: rtl/core_ecc_pkg.sv
// Shared types and Hamming(7,4) helpers for the ECC scheduler.
package core_ecc_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ENC_HOLD = 2'd1,
        DEC_HOLD = 2'd2
    } state_t;

    localparam logic [1:0] CTRL_NET_DEF = 2'd2;

    // Corrected bucket word plus the syndrome that produced it.
    typedef struct packed {
        logic [7:0] word;
        logic [2:0] syn;
    } corr_t;

    // {data[7:4], addr[3:0]} -> {codeword[10:4], addr[3:0]}
    function automatic logic [10:0] ham_encode(input logic [7:0] w);
        logic [10:0] o;
        o       = '0;
        o[3:0]  = w[3:0];
        o[6]    = w[4];
        o[8]    = w[5];
        o[9]    = w[6];
        o[10]   = w[7];
        o[4]    = o[6] ^ o[8] ^ o[10];
        o[5]    = o[6] ^ o[9] ^ o[10];
        o[7]    = o[8] ^ o[9] ^ o[10];
        return o;
    endfunction

    // Single-bit correction; a double-bit error is miscorrected silently.
    function automatic corr_t ham_correct(input logic [10:0] f);
        logic [6:0] r;
        logic [2:0] s;
        corr_t      c;
        r    = f[10:4];
        s[0] = r[0] ^ r[2] ^ r[4] ^ r[6];
        s[1] = r[1] ^ r[2] ^ r[5] ^ r[6];
        s[2] = r[3] ^ r[4] ^ r[5] ^ r[6];
        if (s != 3'd0)
            r[s - 3'd1] = ~r[s - 3'd1];
        c.word = {r[6], r[5], r[4], r[2], f[3:0]};
        c.syn  = s;
        return c;
    endfunction

endpackage

// File: rtl/core_ecc_scheduler_ecc_unit.sv
// Combinational Hamming engine shared by the encode and decode paths.
module ecc_unit
    import core_ecc_pkg::*;
(
    input  logic [7:0]  enc_in,
    input  logic [10:0] dec_in,
    output logic [10:0] enc_out,
    output logic [7:0]  dec_word,
    output logic [2:0]  dec_syn
);

    corr_t corr;

    // Both directions evaluated every cycle; the top picks what it registers.
    always_comb begin
        enc_out  = ham_encode(enc_in);
        corr     = ham_correct(dec_in);
        dec_word = corr.word;
        dec_syn  = corr.syn;
    end

endmodule

// File: rtl/core_ecc_scheduler.sv
// Arbitrates generator and router traffic onto one shared ECC engine.
module core_ecc_scheduler
    import core_ecc_pkg::*;
#(
    parameter logic [1:0] CTRL_NET = CTRL_NET_DEF,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dg_valid,
    output logic             dg_ready,
    input  logic [7:0]       dg_data,
    input  logic             rt_valid,
    output logic             rt_ready,
    input  logic [10:0]      rt_data,
    output logic             net_valid,
    input  logic             net_ready,
    output logic [10:0]      net_data,
    output logic [1:0]       net_ctrl,
    output logic             db_valid,
    input  logic             db_ready,
    output logic [7:0]       db_data,
    output logic             err_corrected,
    output logic             busy,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] dec_count,
    output logic [CNT_W-1:0] corr_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t      state, state_nxt;
    logic        pri, pri_nxt;
    logic        dg_hs, rt_hs;
    logic [10:0] enc_flit;
    logic [7:0]  dec_word;
    logic [2:0]  dec_syn;

    ecc_unit u_ecc (
        .enc_in   (dg_data),
        .dec_in   (rt_data),
        .enc_out  (enc_flit),
        .dec_word (dec_word),
        .dec_syn  (dec_syn)
    );

    assign net_valid = (state == ENC_HOLD);
    assign db_valid  = (state == DEC_HOLD);
    assign busy      = (state != IDLE);
    assign dg_hs     = dg_ready;
    assign rt_hs     = rt_ready;

    // Grant/next-state: pri only flips when both sides compete in IDLE.
    always_comb begin
        state_nxt = state;
        pri_nxt   = pri;
        dg_ready  = 1'b0;
        rt_ready  = 1'b0;
        case (state)
            IDLE: begin
                dg_ready = dg_valid && (!rt_valid || !pri);
                rt_ready = rt_valid && (!dg_valid || pri);
                if (dg_valid && rt_valid)
                    pri_nxt = ~pri;
                if (dg_ready)
                    state_nxt = ENC_HOLD;
                else if (rt_ready)
                    state_nxt = DEC_HOLD;
            end
            ENC_HOLD: if (net_ready) state_nxt = IDLE;
            DEC_HOLD: if (db_ready)  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // FSM and priority pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pri   <= 1'b0;
        end else begin
            state <= state_nxt;
            pri   <= pri_nxt;
        end
    end

    // Output registers load only on the input handshake, so they hold under backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            net_data      <= '0;
            net_ctrl      <= '0;
            db_data       <= '0;
            err_corrected <= 1'b0;
        end else begin
            if (dg_hs) begin
                net_data <= enc_flit;
                net_ctrl <= CTRL_NET;
            end
            if (rt_hs)
                db_data <= dec_word;
            err_corrected <= rt_hs && (dec_syn != 3'd0);
        end
    end

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            enc_count  <= '0;
            dec_count  <= '0;
            corr_count <= '0;
        end else begin
            if (dg_hs && enc_count != '1)
                enc_count <= enc_count + CNT_ONE;
            if (rt_hs && dec_count != '1)
                dec_count <= dec_count + CNT_ONE;
            if (rt_hs && dec_syn != 3'd0 && corr_count != '1)
                corr_count <= corr_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_core_ecc_scheduler.sv
// Directed self-checking bench for core_ecc_scheduler (4-bit counters).
module tb_core_ecc_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        dg_valid, dg_ready;
    logic [7:0]  dg_data;
    logic        rt_valid, rt_ready;
    logic [10:0] rt_data;
    logic        net_valid, net_ready;
    logic [10:0] net_data;
    logic [1:0]  net_ctrl;
    logic        db_valid, db_ready;
    logic [7:0]  db_data;
    logic        err_corrected, busy;
    logic [3:0]  enc_count, dec_count, corr_count;

    int checks = 0;
    int errors = 0;

    core_ecc_scheduler #(.CTRL_NET(2'd2), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .dg_valid(dg_valid), .dg_ready(dg_ready), .dg_data(dg_data),
        .rt_valid(rt_valid), .rt_ready(rt_ready), .rt_data(rt_data),
        .net_valid(net_valid), .net_ready(net_ready), .net_data(net_data), .net_ctrl(net_ctrl),
        .db_valid(db_valid), .db_ready(db_ready), .db_data(db_data),
        .err_corrected(err_corrected), .busy(busy),
        .enc_count(enc_count), .dec_count(dec_count), .corr_count(corr_count)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        dg_valid = 0; rt_valid = 0; dg_data = 0; rt_data = 0;
        net_ready = 0; db_ready = 0;
        do_reset();
        checks++;
        if ({net_valid, db_valid, err_corrected, busy, dg_ready, rt_ready} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 000000",
                     {net_valid, db_valid, err_corrected, busy, dg_ready, rt_ready});
        end
        checks++;
        if ({net_data, net_ctrl, db_data} !== 21'h0) begin
            errors++;
            $display("FAIL reset_data got %h want 0", {net_data, net_ctrl, db_data});
        end
        checks++;
        if ({enc_count, dec_count, corr_count} !== 12'h0) begin
            errors++;
            $display("FAIL reset_counts got %h want 000", {enc_count, dec_count, corr_count});
        end
    endtask

    task automatic test_encode();
        do_reset();
        net_ready = 1; dg_data = 8'hA5; dg_valid = 1;
        #1;
        checks++;
        if ({dg_ready, rt_ready} !== 2'b10) begin
            errors++;
            $display("FAIL enc_grant got %b want 10", {dg_ready, rt_ready});
        end
        step();
        dg_valid = 0;
        #1;
        checks++;
        if ({net_valid, busy, dg_ready, net_data, net_ctrl, enc_count} !== {3'b110, 11'h525, 2'd2, 4'd1}) begin
            errors++;
            $display("FAIL enc_out got v=%b b=%b r=%b d=%h c=%0d n=%0d want v=1 b=1 r=0 d=525 c=2 n=1",
                     net_valid, busy, dg_ready, net_data, net_ctrl, enc_count);
        end
        step();
        checks++;
        if ({net_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL enc_done got v=%b b=%b want 00", net_valid, busy);
        end
    endtask

    task automatic test_decode_clean();
        do_reset();
        db_ready = 1; rt_data = 11'h525; rt_valid = 1;
        #1;
        checks++;
        if ({dg_ready, rt_ready} !== 2'b01) begin
            errors++;
            $display("FAIL dec_grant got %b want 01", {dg_ready, rt_ready});
        end
        step();
        rt_valid = 0;
        checks++;
        if ({db_valid, err_corrected, db_data, dec_count, corr_count} !== {2'b10, 8'hA5, 4'd1, 4'd0}) begin
            errors++;
            $display("FAIL dec_clean got v=%b e=%b d=%h n=%0d c=%0d want v=1 e=0 d=a5 n=1 c=0",
                     db_valid, err_corrected, db_data, dec_count, corr_count);
        end
        step();
        checks++;
        if (db_valid !== 1'b0) begin
            errors++;
            $display("FAIL dec_done got %b want 0", db_valid);
        end
    endtask

    task automatic test_single_bit();
        do_reset();
        db_ready = 1;
        for (int k = 4; k <= 10; k++) begin
            rt_data = 11'h525 ^ (11'h1 << k);
            rt_valid = 1;
            step();
            rt_valid = 0;
            checks++;
            if ({db_valid, err_corrected, db_data, corr_count} !== {2'b11, 8'hA5, 4'(k - 3)}) begin
                errors++;
                $display("FAIL sbe_bit%0d got v=%b e=%b d=%h c=%0d want v=1 e=1 d=a5 c=%0d",
                         k, db_valid, err_corrected, db_data, corr_count, k - 3);
            end
            step();
            checks++;
            if ({db_valid, err_corrected} !== 2'b00) begin
                errors++;
                $display("FAIL sbe_pulse%0d got v=%b e=%b want 00", k, db_valid, err_corrected);
            end
        end
        // 0x425 = bit 8 flipped, explicit vector
        rt_data = 11'h425; rt_valid = 1;
        step();
        rt_valid = 0;
        checks++;
        if ({db_data, dec_count} !== {8'hA5, 4'd8}) begin
            errors++;
            $display("FAIL sbe_425 got d=%h n=%0d want d=a5 n=8", db_data, dec_count);
        end
        step();
    endtask

    task automatic test_contention();
        logic exp_dg;
        do_reset();
        net_ready = 1; db_ready = 1;
        dg_data = 8'h3C; rt_data = 11'h525;
        dg_valid = 1; rt_valid = 1;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_dg = (i % 2 == 0);
            checks++;
            if ({dg_ready, rt_ready} !== {exp_dg, !exp_dg}) begin
                errors++;
                $display("FAIL arb_grant%0d got %b want %b", i, {dg_ready, rt_ready}, {exp_dg, !exp_dg});
            end
            step();
            checks++;
            if ({dg_ready, rt_ready, net_valid, db_valid} !== {2'b00, exp_dg, !exp_dg}) begin
                errors++;
                $display("FAIL arb_hold%0d got %b want %b", i,
                         {dg_ready, rt_ready, net_valid, db_valid}, {2'b00, exp_dg, !exp_dg});
            end
            step();
        end
        // lone router request: pri stays at generator
        dg_valid = 0;
        #1;
        checks++;
        if ({dg_ready, rt_ready} !== 2'b01) begin
            errors++;
            $display("FAIL arb_lone got %b want 01", {dg_ready, rt_ready});
        end
        step();
        step();
        dg_valid = 1;
        #1;
        checks++;
        if ({dg_ready, rt_ready} !== 2'b10) begin
            errors++;
            $display("FAIL arb_after_lone got %b want 10", {dg_ready, rt_ready});
        end
        dg_valid = 0; rt_valid = 0;
        step();
        step();
    endtask

    task automatic test_backpressure_reset();
        do_reset();
        net_ready = 0; db_ready = 0;
        dg_data = 8'h5A; dg_valid = 1;
        rt_data = 11'h525; rt_valid = 1;
        step();
        dg_valid = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({net_valid, dg_ready, rt_ready, net_data} !== {3'b100, 11'h2DA}) begin
                errors++;
                $display("FAIL bp_cycle%0d got v=%b r=%b%b d=%h want v=1 r=00 d=2da",
                         i, net_valid, dg_ready, rt_ready, net_data);
            end
            step();
        end
        net_ready = 1;
        step();
        net_ready = 0;
        checks++;
        if ({net_valid, rt_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_regrant got v=%b r=%b want v=0 r=1", net_valid, rt_ready);
        end
        step();
        rt_valid = 0;
        checks++;
        if ({db_valid, db_data, enc_count, dec_count} !== {1'b1, 8'hA5, 4'd1, 4'd1}) begin
            errors++;
            $display("FAIL bp_dechold got v=%b d=%h e=%0d n=%0d want v=1 d=a5 e=1 n=1",
                     db_valid, db_data, enc_count, dec_count);
        end
        reset = 1;
        step();
        reset = 0;
        checks++;
        if ({db_valid, net_valid, busy, err_corrected, db_data, net_data, net_ctrl,
             enc_count, dec_count, corr_count} !== 37'h0) begin
            errors++;
            $display("FAIL mid_reset got v=%b%b b=%b e=%b dd=%h nd=%h c=%0d cnt=%h want all 0",
                     db_valid, net_valid, busy, err_corrected, db_data, net_data, net_ctrl,
                     {enc_count, dec_count, corr_count});
        end
    endtask

    task automatic test_saturation();
        do_reset();
        net_ready = 1; dg_data = 8'h11; dg_valid = 1;
        for (int i = 0; i < 30; i++) step();
        checks++;
        if (enc_count !== 4'd15) begin
            errors++;
            $display("FAIL sat_15 got %0d want 15", enc_count);
        end
        for (int i = 0; i < 10; i++) step();
        dg_valid = 0;
        step();
        step();
        checks++;
        if (enc_count !== 4'd15) begin
            errors++;
            $display("FAIL sat_20 got %0d want 15", enc_count);
        end
    endtask

    initial begin
        test_reset();
        test_encode();
        test_decode_clean();
        test_single_bit();
        test_contention();
        test_backpressure_reset();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
